// File: rtl/frame_bank_scheduler_if.sv
// Pulse inputs and bank/status outputs of the triple-buffer frame bank scheduler.
// The slave modport is the scheduler; the master modport is whatever drives the pulses.
interface frame_bank_scheduler_if #(
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 16
);
  logic              wr_sof;
  logic              wr_eof;
  logic              rd_sof;
  logic [1:0]        wr_bank;
  logic [1:0]        rd_bank;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] rd_base;
  logic              wr_active;
  logic              rd_valid;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  abort_cnt;
  logic [CNT_W-1:0]  repeat_cnt;

  modport slave (
    input  wr_sof, wr_eof, rd_sof,
    output wr_bank, rd_bank, wr_base, rd_base, wr_active, rd_valid,
           drop_cnt, abort_cnt, repeat_cnt
  );

  modport master (
    output wr_sof, wr_eof, rd_sof,
    input  wr_bank, rd_bank, wr_base, rd_base, wr_active, rd_valid,
           drop_cnt, abort_cnt, repeat_cnt
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler: rotates writer, ready and reader banks so the
// display only ever reads a fully written frame. All outputs are registered.
module frame_bank_scheduler #(
  parameter int FRAME_WORDS = 153600,
  parameter int ADDR_W      = 20,
  parameter int CNT_W       = 16
) (
  input  logic                   Cclk,
  input  logic                   rstn,
  frame_bank_scheduler_if.slave  bus
);

  typedef enum logic {W_IDLE, W_ACTIVE} wstate_e;

  wstate_e           wstate_q, wstate_d;
  logic [1:0]        wr_bank_q, wr_bank_d;
  logic [1:0]        ready_bank_q, ready_bank_d;
  logic [1:0]        rd_bank_q, rd_bank_d;
  logic              ready_valid_q, ready_valid_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  abort_cnt_q, abort_cnt_d;
  logic [CNT_W-1:0]  repeat_cnt_q, repeat_cnt_d;
  logic              complete;

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
    case (idx)
      2'd1:    base_of = ADDR_W'(FRAME_WORDS);
      2'd2:    base_of = ADDR_W'(2 * FRAME_WORDS);
      default: base_of = '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  assign complete = (wstate_q == W_ACTIVE) && bus.wr_eof;

  always_comb begin
    wstate_d      = wstate_q;
    wr_bank_d     = wr_bank_q;
    ready_bank_d  = ready_bank_q;
    rd_bank_d     = rd_bank_q;
    ready_valid_d = ready_valid_q;
    rd_valid_d    = rd_valid_q;
    drop_cnt_d    = drop_cnt_q;
    abort_cnt_d   = abort_cnt_q;
    repeat_cnt_d  = repeat_cnt_q;

    if (complete && bus.rd_sof) begin
      // Reader grabs the just-finished frame; the stale ready frame stays parked.
      rd_bank_d     = wr_bank_q;
      wr_bank_d     = rd_bank_q;
      ready_valid_d = 1'b0;
      rd_valid_d    = 1'b1;
      if (ready_valid_q) drop_cnt_d = sat_inc(drop_cnt_q);
    end else if (complete) begin
      wr_bank_d     = ready_bank_q;
      ready_bank_d  = wr_bank_q;
      ready_valid_d = 1'b1;
      if (ready_valid_q) drop_cnt_d = sat_inc(drop_cnt_q);
    end else if (bus.rd_sof) begin
      if (ready_valid_q) begin
        rd_bank_d     = ready_bank_q;
        ready_bank_d  = rd_bank_q;
        ready_valid_d = 1'b0;
        rd_valid_d    = 1'b1;
      end else if (rd_valid_q) begin
        repeat_cnt_d = sat_inc(repeat_cnt_q);
      end
    end

    case (wstate_q)
      W_IDLE:   if (bus.wr_sof) wstate_d = W_ACTIVE;
      W_ACTIVE: begin
        if (bus.wr_eof)      wstate_d = bus.wr_sof ? W_ACTIVE : W_IDLE;
        else if (bus.wr_sof) abort_cnt_d = sat_inc(abort_cnt_q);
      end
      default:  wstate_d = W_IDLE;
    endcase

    wr_base_d = base_of(wr_bank_d);
    rd_base_d = base_of(rd_bank_d);
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      wstate_q      <= W_IDLE;
      wr_bank_q     <= 2'd0;
      ready_bank_q  <= 2'd1;
      rd_bank_q     <= 2'd2;
      ready_valid_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      wr_base_q     <= '0;
      rd_base_q     <= ADDR_W'(2 * FRAME_WORDS);
      drop_cnt_q    <= '0;
      abort_cnt_q   <= '0;
      repeat_cnt_q  <= '0;
    end else begin
      wstate_q      <= wstate_d;
      wr_bank_q     <= wr_bank_d;
      ready_bank_q  <= ready_bank_d;
      rd_bank_q     <= rd_bank_d;
      ready_valid_q <= ready_valid_d;
      rd_valid_q    <= rd_valid_d;
      wr_base_q     <= wr_base_d;
      rd_base_q     <= rd_base_d;
      drop_cnt_q    <= drop_cnt_d;
      abort_cnt_q   <= abort_cnt_d;
      repeat_cnt_q  <= repeat_cnt_d;
    end
  end

  assign bus.wr_bank    = wr_bank_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.wr_base    = wr_base_q;
  assign bus.rd_base    = rd_base_q;
  assign bus.wr_active  = (wstate_q == W_ACTIVE);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.abort_cnt  = abort_cnt_q;
  assign bus.repeat_cnt = repeat_cnt_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Scoreboard bench for frame_bank_scheduler: a bank-rotation model queues the
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_frame_bank_scheduler;
  localparam int FW     = 153600;
  localparam int ADDR_W = 20;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic Cclk = 1'b0;
  logic rstn = 1'b1;
  always #5 Cclk = ~Cclk;

  frame_bank_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  frame_bank_scheduler #(.FRAME_WORDS(FW), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Cclk (Cclk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    int wr; int rd; int wrb; int rdb; int act; int rdv; int drop; int abort; int rep;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  int m_wr, m_rdy, m_rd, m_rv, m_rdv, m_act, m_drop, m_abort, m_rep;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge Cclk) chk("bank_ne", longint'(bus.wr_bank != bus.rd_bank), 1);

  function automatic int base_of(input int b);
    return (b == 1) ? FW : (b == 2) ? 2 * FW : 0;
  endfunction

  function automatic int sat(input int c);
    return (c >= MAXC) ? MAXC : c + 1;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.wr = m_wr; e.rd = m_rd; e.wrb = base_of(m_wr); e.rdb = base_of(m_rd);
    e.act = m_act; e.rdv = m_rdv; e.drop = m_drop; e.abort = m_abort; e.rep = m_rep;
    return e;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rdy = 1; m_rd = 2; m_rv = 0; m_rdv = 0; m_act = 0;
    m_drop = 0; m_abort = 0; m_rep = 0;
  endtask

  task automatic model_step(input bit s, input bit e, input bit r);
    int t;
    bit done;
    done = (m_act != 0) && e;
    if (done && r) begin
      t = m_wr; m_wr = m_rd; m_rd = t;
      if (m_rv != 0) m_drop = sat(m_drop);
      m_rv = 0; m_rdv = 1;
    end else if (done) begin
      t = m_wr; m_wr = m_rdy; m_rdy = t;
      if (m_rv != 0) m_drop = sat(m_drop);
      m_rv = 1;
    end else if (r) begin
      if (m_rv != 0) begin
        t = m_rd; m_rd = m_rdy; m_rdy = t; m_rv = 0; m_rdv = 1;
      end else if (m_rdv != 0) begin
        m_rep = sat(m_rep);
      end
    end
    if (m_act != 0 && s && !e) m_abort = sat(m_abort);
    if (m_act == 0) m_act = s ? 1 : 0;
    else if (e)     m_act = s ? 1 : 0;
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, q.size(), 1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_wr_bank"},   bus.wr_bank,    e.wr);
    chk({tag, "_rd_bank"},   bus.rd_bank,    e.rd);
    chk({tag, "_wr_base"},   bus.wr_base,    e.wrb);
    chk({tag, "_rd_base"},   bus.rd_base,    e.rdb);
    chk({tag, "_wr_active"}, bus.wr_active,  e.act);
    chk({tag, "_rd_valid"},  bus.rd_valid,   e.rdv);
    chk({tag, "_drop"},      bus.drop_cnt,   e.drop);
    chk({tag, "_abort"},     bus.abort_cnt,  e.abort);
    chk({tag, "_repeat"},    bus.repeat_cnt, e.rep);
  endtask

  task automatic cycle(input bit s, input bit e, input bit r, input string tag);
    @(negedge Cclk);
    bus.wr_sof = s; bus.wr_eof = e; bus.rd_sof = r;
    model_step(s, e, r);
    q.push_back(cur_exp());
    @(posedge Cclk);
    #1;
    bus.wr_sof = 1'b0; bus.wr_eof = 1'b0; bus.rd_sof = 1'b0;
    pop_compare(tag);
  endtask

  task automatic do_reset();
    @(negedge Cclk);
    rstn = 1'b0;
    model_reset();
    q.push_back(cur_exp());
    #1;
    pop_compare("rst");
    @(negedge Cclk);
    rstn = 1'b1;
  endtask

  initial begin
    bus.wr_sof = 1'b0; bus.wr_eof = 1'b0; bus.rd_sof = 1'b0;
    #1 rstn = 1'b0;

    // Reset values, then rd_sof with nothing ready
    do_reset();
    chk("rst_wr_bank", bus.wr_bank, 0);
    chk("rst_rd_bank", bus.rd_bank, 2);
    chk("rst_wr_base", bus.wr_base, 0);
    chk("rst_rd_base", bus.rd_base, 307200);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    cycle(0, 0, 1, "rsof0");
    chk("rsof0_rd_bank", bus.rd_bank, 2);
    chk("rsof0_repeat", bus.repeat_cnt, 0);

    // One frame then read
    do_reset();
    cycle(1, 0, 0, "f1_sof");
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, "f1_body");
    cycle(0, 1, 0, "f1_eof");
    chk("f1_wr_bank", bus.wr_bank, 1);
    chk("f1_wr_base", bus.wr_base, 153600);
    chk("f1_wr_active", bus.wr_active, 0);
    cycle(0, 0, 1, "f1_rd");
    chk("f1_rd_bank", bus.rd_bank, 0);
    chk("f1_rd_base", bus.rd_base, 0);
    chk("f1_rd_valid", bus.rd_valid, 1);
    cycle(0, 0, 1, "f1_rd2");
    chk("f1_rd2_bank", bus.rd_bank, 0);
    chk("f1_repeat", bus.repeat_cnt, 1);

    // Two frames, no read between: one drop
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 0, "f2_sof");
      cycle(0, 0, 0, "f2_body");
      cycle(0, 1, 0, "f2_eof");
    end
    chk("f2_wr_bank", bus.wr_bank, 0);
    chk("f2_drop", bus.drop_cnt, 1);
    cycle(0, 0, 1, "f2_rd");
    chk("f2_rd_bank", bus.rd_bank, 1);

    // Completion and rd_sof together
    do_reset();
    cycle(1, 0, 0, "co_sof");
    cycle(0, 0, 0, "co_body");
    cycle(0, 1, 1, "co_eof_rd");
    chk("co_rd_bank", bus.rd_bank, 0);
    chk("co_wr_bank", bus.wr_bank, 2);
    chk("co_rd_valid", bus.rd_valid, 1);
    chk("co_drop", bus.drop_cnt, 0);

    // Abort, then eof+sof together
    do_reset();
    cycle(1, 0, 0, "ab_sof");
    cycle(0, 0, 0, "ab_body");
    cycle(1, 0, 0, "ab_sof2");
    chk("ab_abort", bus.abort_cnt, 1);
    chk("ab_wr_bank", bus.wr_bank, 0);
    cycle(1, 1, 0, "ab_eof_sof");
    chk("es_wr_bank", bus.wr_bank, 1);
    chk("es_wr_active", bus.wr_active, 1);
    chk("es_abort", bus.abort_cnt, 1);

    // Reset mid-frame, stray eof ignored
    cycle(0, 0, 0, "mid_body");
    do_reset();
    cycle(0, 1, 0, "stray_eof");
    chk("stray_wr_bank", bus.wr_bank, 0);
    chk("stray_rd_bank", bus.rd_bank, 2);
    chk("stray_wr_active", bus.wr_active, 0);

    // Drive drop_cnt into saturation
    for (int k = 0; k < MAXC + 4; k++) begin
      cycle(1, 0, 0, "sat_sof");
      cycle(0, 1, 0, "sat_eof");
    end
    chk("sat_drop", bus.drop_cnt, MAXC);

    // Random pulse traffic through the scoreboard
    do_reset();
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
